gamma_scheduler: RTL and testbench

//  Sequences the soft_gamma branch-metric unit over every (t, d, d_tag, b) trellis branch of one frame.

---
 rtl/gamma_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_gamma_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_scheduler.sv
// Walks every legal (t, d, d_tag, b) trellis branch of a frame, issues gamma requests under
// buffer credit, and streams the in-order tagged results to the recursion datapath.
//
//  state | meaning
//  IDLE  | waiting for start
//  ISSUE | walking branches, one request per accepted handshake
//  DRAIN | all requests issued, waiting for responses and downstream pops
//  DONE  | one-cycle done pulse, then back to IDLE
module gamma_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int T_W        = 6,
    parameter int D_MAX      = 7,
    parameter int D_W        = 3,
    parameter int GAMMA_W    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [T_W-1:0]     t_len,
    input  logic [5:0]         n_len,
    output logic               busy,
    output logic               done,
    output logic               gm_req_valid,
    input  logic               gm_req_ready,
    output logic [T_W-1:0]     gm_t,
    output logic [D_W-1:0]     gm_d,
    output logic [D_W-1:0]     gm_d_tag,
    output logic               gm_b,
    input  logic               gm_rsp_valid,
    input  logic [GAMMA_W-1:0] gm_rsp_gamma,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [T_W-1:0]     out_t,
    output logic [D_W-1:0]     out_d,
    output logic [D_W-1:0]     out_d_tag,
    output logic               out_b,
    output logic [GAMMA_W-1:0] out_gamma
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_W = T_W + 2 * D_W + 1;
    localparam int SR_W  = D_W + 3;

    // Returns {found, d, k} for the first legal (d, k) pair of time t after flat index cur (d*3+k).
    // k encodes d_tag - d + 1. Loops run backwards so the lowest qualifying index wins.
    function automatic logic [SR_W-1:0] find_pair(input int t, input int n, input int cur);
        logic [SR_W-1:0] r;
        int dt;
        r = '0;
        for (int dd = D_MAX; dd >= 0; dd--) begin
            for (int kk = 2; kk >= 0; kk--) begin
                dt = dd + kk - 1;
                if ((dd * 3 + kk > cur) && (dt >= 0) && (dt <= D_MAX) && (t + dt <= n))
                    r = {1'b1, dd[D_W-1:0], kk[1:0]};
            end
        end
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [T_W-1:0]  t_q, t_d, tlen_q, tlen_d;
    logic [5:0]      nlen_q, nlen_d;
    logic [D_W-1:0]  d_q, d_d;
    logic [1:0]      k_q, k_d;
    logic            b_q, b_d;

    logic [PTR_W-1:0] wr_ptr_q, fill_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] used_q, used_d, outst_q, outst_d;
    logic [TAG_W-1:0]   tag_q   [FIFO_DEPTH];
    logic [GAMMA_W-1:0] gamma_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] filled_q;

    logic [SR_W-1:0] first_w, nxt_same_w, nxt_t_w;
    logic fire, pop, rsp_take;

    assign gm_req_valid = (state_q == ISSUE) && (used_q < CNT_W'(FIFO_DEPTH));
    assign fire         = gm_req_valid && gm_req_ready;
    assign pop          = out_valid && out_ready;
    assign rsp_take     = gm_rsp_valid && (outst_q != '0);

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign gm_t     = t_q;
    assign gm_d     = d_q;
    assign gm_d_tag = d_q + D_W'(k_q) - D_W'(1);
    assign gm_b     = b_q;

    assign out_valid = filled_q[rd_ptr_q];
    assign {out_t, out_d, out_d_tag, out_b} = tag_q[rd_ptr_q];
    assign out_gamma = gamma_q[rd_ptr_q];

    always_comb begin
        first_w    = find_pair(0, int'(n_len), -1);
        nxt_same_w = find_pair(int'(t_q), int'(nlen_q), int'(d_q) * 3 + int'(k_q));
        nxt_t_w    = find_pair(int'(t_q) + 1, int'(nlen_q), -1);
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        d_d     = d_q;
        k_d     = k_q;
        b_d     = b_q;
        tlen_d  = tlen_q;
        nlen_d  = nlen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tlen_d = t_len;
                    nlen_d = n_len;
                    t_d    = '0;
                    b_d    = 1'b0;
                    if ((t_len == '0) || !first_w[SR_W-1]) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                        d_d     = first_w[D_W+1:2];
                        k_d     = first_w[1:0];
                    end
                end
            end
            ISSUE: begin
                if (fire) begin
                    if (!b_q) begin
                        b_d = 1'b1;
                    end else begin
                        b_d = 1'b0;
                        if (nxt_same_w[SR_W-1]) begin
                            d_d = nxt_same_w[D_W+1:2];
                            k_d = nxt_same_w[1:0];
                        end else if ((int'(t_q) + 1 < int'(tlen_q)) && nxt_t_w[SR_W-1]) begin
                            t_d = t_q + T_W'(1);
                            d_d = nxt_t_w[D_W+1:2];
                            k_d = nxt_t_w[1:0];
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if ((used_q == '0) && (outst_q == '0))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        used_d = used_q;
        if (fire && !pop)
            used_d = used_q + CNT_W'(1);
        else if (!fire && pop)
            used_d = used_q - CNT_W'(1);
        outst_d = outst_q;
        if (fire && !rsp_take)
            outst_d = outst_q + CNT_W'(1);
        else if (!fire && rsp_take)
            outst_d = outst_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            d_q     <= '0;
            k_q     <= 2'd1;
            b_q     <= 1'b0;
            tlen_q  <= '0;
            nlen_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
            k_q     <= k_d;
            b_q     <= b_d;
            tlen_q  <= tlen_d;
            nlen_q  <= nlen_d;
        end
    end

    // Reserve, fill and pop never touch the same entry in one cycle, so the writes are independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            used_q     <= '0;
            outst_q    <= '0;
            filled_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i]   <= '0;
                gamma_q[i] <= '0;
            end
        end else begin
            used_q  <= used_d;
            outst_q <= outst_d;
            if (fire) begin
                tag_q[wr_ptr_q]    <= {gm_t, gm_d, gm_d_tag, gm_b};
                filled_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (rsp_take) begin
                gamma_q[fill_ptr_q]  <= gm_rsp_gamma;
                filled_q[fill_ptr_q] <= 1'b1;
                fill_ptr_q           <= fill_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                filled_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q           <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gamma_scheduler.sv
// Directed bench for gamma_scheduler with D_MAX=1: a behavioural gamma unit answers in order
// with gamma equal to the zero-extended branch tag, and results are compared to an enumerated branch list.
module tb_gamma_scheduler;

    localparam int T_W     = 6;
    localparam int D_MAX   = 1;
    localparam int D_W     = 1;
    localparam int GAMMA_W = 16;
    localparam int FD      = 8;
    localparam int TAG_W   = T_W + 2 * D_W + 1;

    logic               clk, rst_n, start;
    logic [T_W-1:0]     t_len;
    logic [5:0]         n_len;
    logic               busy, done;
    logic               gm_req_valid, gm_req_ready;
    logic [T_W-1:0]     gm_t;
    logic [D_W-1:0]     gm_d, gm_d_tag;
    logic               gm_b;
    logic               gm_rsp_valid;
    logic [GAMMA_W-1:0] gm_rsp_gamma;
    logic               out_valid, out_ready;
    logic [T_W-1:0]     out_t;
    logic [D_W-1:0]     out_d, out_d_tag;
    logic               out_b;
    logic [GAMMA_W-1:0] out_gamma;

    gamma_scheduler #(
        .DATA_WIDTH(32), .T_W(T_W), .D_MAX(D_MAX), .D_W(D_W),
        .GAMMA_W(GAMMA_W), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .t_len(t_len), .n_len(n_len),
        .busy(busy), .done(done),
        .gm_req_valid(gm_req_valid), .gm_req_ready(gm_req_ready),
        .gm_t(gm_t), .gm_d(gm_d), .gm_d_tag(gm_d_tag), .gm_b(gm_b),
        .gm_rsp_valid(gm_rsp_valid), .gm_rsp_gamma(gm_rsp_gamma),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_t(out_t), .out_d(out_d), .out_d_tag(out_d_tag), .out_b(out_b),
        .out_gamma(out_gamma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               due;
    } req_t;

    req_t             req_q[$];
    logic [TAG_W-1:0] obs_tag[$];
    logic [GAMMA_W-1:0] obs_gam[$];
    logic [TAG_W-1:0] exp_q[$];

    int cyc = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit rand_ready = 1'b0;
    int total = 0;
    int bad = 0;

    // Monitor: handshakes are sampled with pre-edge values.
    always @(posedge clk) begin
        if (rst_n) begin
            if (gm_rsp_valid && req_q.size() > 0)
                req_q.delete(0);
            if (gm_req_valid && gm_req_ready) begin
                req_t r;
                r.tag = {gm_t, gm_d, gm_d_tag, gm_b};
                r.due = cyc + int'($urandom_range(lat_max, lat_min));
                req_q.push_back(r);
                req_cnt++;
            end
            if (out_valid && out_ready) begin
                obs_tag.push_back({out_t, out_d, out_d_tag, out_b});
                obs_gam.push_back(out_gamma);
            end
            if (done)
                done_cnt++;
        end
        cyc++;
    end

    // Gamma unit model: in-order responses, at most one per cycle, cleared by reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_q.delete();
            gm_rsp_valid = 1'b0;
            gm_rsp_gamma = '0;
        end else if (req_q.size() > 0 && req_q[0].due <= cyc) begin
            gm_rsp_valid = 1'b1;
            gm_rsp_gamma = GAMMA_W'(req_q[0].tag);
        end else begin
            gm_rsp_valid = 1'b0;
            gm_rsp_gamma = '0;
        end
        gm_req_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    task automatic build_exp(input int tl, input int nl);
        exp_q.delete();
        for (int t = 0; t < tl; t++)
            for (int d = 0; d <= D_MAX; d++)
                for (int dt = d - 1; dt <= d + 1; dt++)
                    if (dt >= 0 && dt <= D_MAX && t + dt <= nl)
                        for (int b = 0; b < 2; b++)
                            exp_q.push_back({T_W'(t), D_W'(d), D_W'(dt), 1'(b)});
    endtask

    task automatic kick(input int tl, input int nl);
        obs_tag.delete();
        obs_gam.delete();
        req_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        t_len = T_W'(tl);
        n_len = 6'(nl);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > 0) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, gm_req_valid, out_valid} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=0000", {busy, done, gm_req_valid, out_valid});
        end
        total++;
        if ({out_t, out_d, out_d_tag, out_b, out_gamma} !== '0) begin
            bad++;
            $display("FAIL reset_tag got t=%0d g=%h exp 0", out_t, out_gamma);
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        lat_min = 1; lat_max = 1; rand_ready = 1'b0; out_ready = 1'b1;
        build_exp(2, 2);
        kick(2, 2);
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t1_done_timeout got=0 exp=1"); end
        total++;
        if (obs_tag.size() != 16) begin bad++; $display("FAIL t1_count got=%0d exp=16", obs_tag.size()); end
        total++;
        if (obs_tag.size() > 0 && obs_tag[0] !== 9'b000000_0_0_0) begin
            bad++; $display("FAIL t1_first got=%h exp=%h", obs_tag[0], 9'b000000_0_0_0);
        end
        total++;
        if (obs_tag.size() > 0 && obs_tag[obs_tag.size()-1] !== 9'b000001_1_1_1) begin
            bad++; $display("FAIL t1_last got=%h exp=%h", obs_tag[obs_tag.size()-1], 9'b000001_1_1_1);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL t1_done_once got=%0d exp=1", done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%b exp=0", busy); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_tag.size() || obs_tag[i] !== exp_q[i] || obs_gam[i] !== GAMMA_W'(exp_q[i])) begin
                bad++;
                $display("FAIL t1_item%0d got=%h/%h exp=%h", i, (i < obs_tag.size()) ? obs_tag[i] : 'x,
                         (i < obs_gam.size()) ? obs_gam[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_skip();
        bit ok;
        int n_t1;
        lat_min = 1; lat_max = 1; rand_ready = 1'b0; out_ready = 1'b1;
        build_exp(2, 1);
        kick(2, 1);
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t2_done_timeout got=0 exp=1"); end
        total++;
        if (obs_tag.size() != 12) begin bad++; $display("FAIL t2_count got=%0d exp=12", obs_tag.size()); end
        n_t1 = 0;
        for (int i = 0; i < obs_tag.size(); i++) begin
            if (obs_tag[i][TAG_W-1 -: T_W] == T_W'(1)) begin
                n_t1++;
                total++;
                if (obs_tag[i][1] !== 1'b0) begin
                    bad++; $display("FAIL t2_dtag_t1 item%0d got=%b exp=0", i, obs_tag[i][1]);
                end
            end
        end
        total++;
        if (n_t1 != 4) begin bad++; $display("FAIL t2_t1_count got=%0d exp=4", n_t1); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_tag.size() || obs_tag[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL t2_item%0d got=%h exp=%h", i, (i < obs_tag.size()) ? obs_tag[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        lat_min = 1; lat_max = 1; rand_ready = 1'b0; out_ready = 1'b0;
        build_exp(2, 2);
        kick(2, 2);
        repeat (30) @(negedge clk);
        total++;
        if (req_cnt != FD) begin bad++; $display("FAIL t3_credit got=%0d exp=%0d", req_cnt, FD); end
        total++;
        if (gm_req_valid !== 1'b0) begin bad++; $display("FAIL t3_req_stall got=%b exp=0", gm_req_valid); end
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL t3_hold got=%b%b exp=11", out_valid, busy);
        end
        out_ready = 1'b1;
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t3_done_timeout got=0 exp=1"); end
        total++;
        if (req_cnt != 16 || obs_tag.size() != 16) begin
            bad++; $display("FAIL t3_count got=%0d/%0d exp=16", req_cnt, obs_tag.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_tag.size() || obs_tag[i] !== exp_q[i] || obs_gam[i] !== GAMMA_W'(exp_q[i])) begin
                bad++;
                $display("FAIL t3_item%0d got=%h exp=%h", i, (i < obs_tag.size()) ? obs_tag[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_latency();
        bit ok;
        lat_min = 1; lat_max = 5; rand_ready = 1'b1; out_ready = 1'b1;
        build_exp(3, 2);
        kick(3, 2);
        wait_done(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t4_done_timeout got=0 exp=1"); end
        total++;
        if (obs_tag.size() != 20) begin bad++; $display("FAIL t4_count got=%0d exp=20", obs_tag.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_tag.size() || obs_tag[i] !== exp_q[i] || obs_gam[i] !== GAMMA_W'(exp_q[i])) begin
                bad++;
                $display("FAIL t4_item%0d got=%h/%h exp=%h", i, (i < obs_tag.size()) ? obs_tag[i] : 'x,
                         (i < obs_gam.size()) ? obs_gam[i] : 'x, exp_q[i]);
            end
        end
        rand_ready = 1'b0;
        lat_max = 1;
    endtask

    task automatic test_empty_frame();
        bit ok;
        out_ready = 1'b1;
        kick(0, 5);
        wait_done(3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t5_done_late got=0 exp=1"); end
        total++;
        if (req_cnt != 0) begin bad++; $display("FAIL t5_no_req got=%0d exp=0", req_cnt); end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL t5_end got done=%0d busy=%b exp 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        lat_min = 4; lat_max = 4; rand_ready = 1'b0; out_ready = 1'b1;
        kick(2, 2);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_cnt >= 3) ok = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok || req_q.size() != 3) begin
            bad++; $display("FAIL t6_outstanding got=%0d exp=3", req_q.size());
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || gm_req_valid !== 1'b0) begin
            bad++; $display("FAIL t6_async got=%b%b exp=00", busy, gm_req_valid);
        end
        @(negedge clk);
        total++;
        if ({busy, done, gm_req_valid, out_valid, out_t, out_d, out_d_tag, out_b, out_gamma} !== '0) begin
            bad++; $display("FAIL t6_cleared got busy=%b req=%b ov=%b t=%0d g=%h exp 0",
                            busy, gm_req_valid, out_valid, out_t, out_gamma);
        end
        rst_n = 1'b1;
        @(negedge clk);
        build_exp(2, 2);
        kick(2, 2);
        wait_done(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t6_done_timeout got=0 exp=1"); end
        total++;
        if (obs_tag.size() != 16 || done_cnt != 1) begin
            bad++; $display("FAIL t6_count got=%0d done=%0d exp=16/1", obs_tag.size(), done_cnt);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_tag.size() || obs_tag[i] !== exp_q[i] || obs_gam[i] !== GAMMA_W'(exp_q[i])) begin
                bad++;
                $display("FAIL t6_item%0d got=%h exp=%h", i, (i < obs_tag.size()) ? obs_tag[i] : 'x, exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        t_len = '0;
        n_len = '0;
        out_ready = 1'b1;
        gm_req_ready = 1'b1;
        gm_rsp_valid = 1'b0;
        gm_rsp_gamma = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_full_frame();
        test_skip();
        test_backpressure();
        test_random_latency();
        test_empty_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
